// File: rtl/lbdr_pkt_pkg.sv
// rtl/lbdr_pkt_pkg.sv - flit codes, port/state enums and bit positions for the LBDR router slice
package lbdr_pkg;

   localparam logic [2:0] FLIT_HEADER    = 3'b001;
   localparam logic [2:0] FLIT_BODY      = 3'b010;
   localparam logic [2:0] FLIT_TAIL      = 3'b100;
   localparam logic [2:0] FLIT_HEAD_TAIL = 3'b101;

   // Bit positions inside the 5-bit route vector {L,S,W,E,N}; N..S match the Dr encoding
   localparam int P_N = 0;
   localparam int P_E = 1;
   localparam int P_W = 2;
   localparam int P_S = 3;
   localparam int P_L = 4;

   // Bit positions inside Rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
   localparam int R_NE = 0;
   localparam int R_NW = 1;
   localparam int R_EN = 2;
   localparam int R_ES = 3;
   localparam int R_WN = 4;
   localparam int R_WS = 5;
   localparam int R_SE = 6;
   localparam int R_SW = 7;

   typedef enum logic [1:0] {
      PORT_N = 2'b00,
      PORT_E = 2'b01,
      PORT_W = 2'b10,
      PORT_S = 2'b11
   } port_sel_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ROUTE = 2'b01,
      ST_DROP  = 2'b10
   } state_e;

endpackage

// File: rtl/lbdr_pkt_if.sv
// rtl/lbdr_pkt_if.sv - flit input, reset-time configuration and route outputs of one input port
interface lbdr_pkt_if #(
   parameter int X_BITS = 2,
   parameter int Y_BITS = 2
);
   logic                       empty;
   logic [2:0]                 flit_id;
   logic [X_BITS+Y_BITS-1:0]   dst_addr;
   logic [X_BITS+Y_BITS-1:0]   cur_addr_rst;
   logic [7:0]                 Rxy_rst;
   logic [3:0]                 Cx_rst;
   logic [1:0]                 Dr_rst;
   logic                       Nport;
   logic                       Eport;
   logic                       Wport;
   logic                       Sport;
   logic                       Lport;
   logic                       busy;
   logic                       route_err;

   modport master (
      output empty, flit_id, dst_addr, cur_addr_rst, Rxy_rst, Cx_rst, Dr_rst,
      input  Nport, Eport, Wport, Sport, Lport, busy, route_err
   );

   modport slave (
      input  empty, flit_id, dst_addr, cur_addr_rst, Rxy_rst, Cx_rst, Dr_rst,
      output Nport, Eport, Wport, Sport, Lport, busy, route_err
   );

endinterface

// File: rtl/lbdr_pkt_route_comb.sv
// rtl/lbdr_pkt_route_comb.sv - combinational LBDR minimal route with optional single-hop deroute
module lbdr_route_comb
   import lbdr_pkg::*;
#(
   parameter int X_BITS     = 2,
   parameter int Y_BITS     = 2,
   parameter int EN_DEROUTE = 1
) (
   input  logic [X_BITS+Y_BITS-1:0] cur_i,
   input  logic [X_BITS+Y_BITS-1:0] dst_i,
   input  logic [7:0]               rxy_i,
   input  logic [3:0]               cx_i,
   input  port_sel_e                dr_i,
   output logic [4:0]               route_o,
   output logic                     routable_o
);

   logic [X_BITS-1:0] x_cur, x_dst;
   logic [Y_BITS-1:0] y_cur, y_dst;
   logic              n1, s1, e1, w1;
   logic              rt_n, rt_e, rt_w, rt_s, rt_l;
   logic [1:0]        dr_idx;

   assign x_cur = cur_i[X_BITS-1:0];
   assign y_cur = cur_i[X_BITS+:Y_BITS];
   assign x_dst = dst_i[X_BITS-1:0];
   assign y_dst = dst_i[X_BITS+:Y_BITS];

   assign n1 = y_dst < y_cur;
   assign s1 = y_cur < y_dst;
   assign e1 = x_cur < x_dst;
   assign w1 = x_dst < x_cur;

   assign rt_n = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_i[R_NE]) | (n1 & w1 & rxy_i[R_NW])) & cx_i[P_N];
   assign rt_e = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_i[R_EN]) | (e1 & s1 & rxy_i[R_ES])) & cx_i[P_E];
   assign rt_w = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_i[R_WN]) | (w1 & s1 & rxy_i[R_WS])) & cx_i[P_W];
   assign rt_s = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_i[R_SE]) | (s1 & w1 & rxy_i[R_SW])) & cx_i[P_S];
   assign rt_l = ~n1 & ~e1 & ~w1 & ~s1;

   assign dr_idx = dr_i;

   // Dr encoding equals the N/E/W/S bit position, so the deroute is a plain shift
   always_comb begin
      route_o = {rt_l, rt_s, rt_w, rt_e, rt_n};
      if (route_o == 5'b00000 && EN_DEROUTE != 0 && cx_i[dr_idx]) begin
         route_o = 5'b00001 << dr_idx;
      end
   end

   assign routable_o = |route_o;

endmodule

// File: rtl/lbdr_pkt.sv
// rtl/lbdr_pkt.sv - per-input-port LBDR router with packet FSM holding the route until the tail
module lbdr_pkt
   import lbdr_pkg::*;
#(
   parameter int X_BITS     = 2,
   parameter int Y_BITS     = 2,
   parameter int EN_DEROUTE = 1
) (
   input  logic  clk,
   input  logic  rst,
   lbdr_pkt_if.slave bus
);

   localparam int A_BITS = X_BITS + Y_BITS;

   logic [A_BITS-1:0] cur_q;
   logic [7:0]        rxy_q;
   logic [3:0]        cx_q;
   port_sel_e         dr_q;

   state_e            state_q, state_d;
   logic [4:0]        ports_q, ports_d;
   logic              busy_q;
   logic              err_q, err_d;

   logic [4:0]        route;
   logic              routable;
   logic              is_hdr, is_ht, is_tail;
   state_e            hdr_state;
   logic [4:0]        hdr_ports;

   lbdr_route_comb #(
      .X_BITS     (X_BITS),
      .Y_BITS     (Y_BITS),
      .EN_DEROUTE (EN_DEROUTE)
   ) u_route (
      .cur_i      (cur_q),
      .dst_i      (bus.dst_addr),
      .rxy_i      (rxy_q),
      .cx_i       (cx_q),
      .dr_i       (dr_q),
      .route_o    (route),
      .routable_o (routable)
   );

   assign is_hdr  = (bus.flit_id == FLIT_HEADER);
   assign is_ht   = (bus.flit_id == FLIT_HEAD_TAIL);
   assign is_tail = (bus.flit_id == FLIT_TAIL);

   // Outcome of taking the current flit as a fresh header; a HEAD_TAIL never leaves IDLE
   assign hdr_ports = routable ? route : 5'b00000;
   assign hdr_state = is_ht ? ST_IDLE : (routable ? ST_ROUTE : ST_DROP);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cur_q   <= bus.cur_addr_rst;
         rxy_q   <= bus.Rxy_rst;
         cx_q    <= bus.Cx_rst;
         dr_q    <= port_sel_e'(bus.Dr_rst);
         state_q <= ST_IDLE;
         ports_q <= 5'b00000;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ports_q <= ports_d;
         busy_q  <= (state_d != ST_IDLE);
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ports_d = ports_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ports_d = 5'b00000;
            if (!bus.empty) begin
               if (is_hdr || is_ht) begin
                  state_d = hdr_state;
                  ports_d = hdr_ports;
                  err_d   = ~routable;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_ROUTE: begin
            if (!bus.empty) begin
               if (is_tail) begin
                  state_d = ST_IDLE;
                  ports_d = 5'b00000;
               end else if (is_hdr || is_ht) begin
                  state_d = hdr_state;
                  ports_d = hdr_ports;
                  err_d   = 1'b1;
               end
            end
         end
         ST_DROP: begin
            ports_d = 5'b00000;
            if (!bus.empty && is_tail) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            ports_d = 5'b00000;
         end
      endcase
   end

   assign bus.Nport     = ports_q[P_N];
   assign bus.Eport     = ports_q[P_E];
   assign bus.Wport     = ports_q[P_W];
   assign bus.Sport     = ports_q[P_S];
   assign bus.Lport     = ports_q[P_L];
   assign bus.busy      = busy_q;
   assign bus.route_err = err_q;

endmodule

// File: tb/tb_lbdr_pkt.sv
// tb/tb_lbdr_pkt.sv - vector table, random model comparison and wide-mesh reset sequence for lbdr_pkt
module tb_lbdr_pkt;

   localparam logic [2:0] H  = 3'b001;
   localparam logic [2:0] B  = 3'b010;
   localparam logic [2:0] T  = 3'b100;
   localparam logic [2:0] HT = 3'b101;
   localparam logic [4:0] PN = 5'b00001;
   localparam logic [4:0] PE = 5'b00010;
   localparam logic [4:0] PW = 5'b00100;
   localparam logic [4:0] PS = 5'b01000;
   localparam logic [4:0] PL = 5'b10000;
   localparam logic [4:0] PZ = 5'b00000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, empty;
   logic [2:0] fid;
   logic [3:0] dst, cur, cx;
   logic [7:0] rxy;
   logic [1:0] dr;

   logic       rst2, empty2;
   logic [2:0] fid2;
   logic [5:0] dst2, cur2;

   int checks = 0;
   int errors = 0;

   lbdr_pkt_if #(.X_BITS(2), .Y_BITS(2)) if0 ();
   lbdr_pkt_if #(.X_BITS(2), .Y_BITS(2)) if1 ();
   lbdr_pkt_if #(.X_BITS(3), .Y_BITS(3)) if2 ();

   assign if0.empty = empty;  assign if0.flit_id = fid;  assign if0.dst_addr = dst;
   assign if0.cur_addr_rst = cur;  assign if0.Rxy_rst = rxy;  assign if0.Cx_rst = cx;  assign if0.Dr_rst = dr;
   assign if1.empty = empty;  assign if1.flit_id = fid;  assign if1.dst_addr = dst;
   assign if1.cur_addr_rst = cur;  assign if1.Rxy_rst = rxy;  assign if1.Cx_rst = cx;  assign if1.Dr_rst = dr;
   assign if2.empty = empty2; assign if2.flit_id = fid2; assign if2.dst_addr = dst2;
   assign if2.cur_addr_rst = cur2; assign if2.Rxy_rst = 8'h3C; assign if2.Cx_rst = 4'hF; assign if2.Dr_rst = 2'b00;

   lbdr_pkt #(.X_BITS(2), .Y_BITS(2), .EN_DEROUTE(1)) dut0 (.clk(clk), .rst(rst),  .bus(if0.slave));
   lbdr_pkt #(.X_BITS(2), .Y_BITS(2), .EN_DEROUTE(0)) dut1 (.clk(clk), .rst(rst),  .bus(if1.slave));
   lbdr_pkt #(.X_BITS(3), .Y_BITS(3), .EN_DEROUTE(1)) dut2 (.clk(clk), .rst(rst2), .bus(if2.slave));

   function automatic logic [4:0] ports_of0();
      return {if0.Lport, if0.Sport, if0.Wport, if0.Eport, if0.Nport};
   endfunction
   function automatic logic [4:0] ports_of1();
      return {if1.Lport, if1.Sport, if1.Wport, if1.Eport, if1.Nport};
   endfunction
   function automatic logic [4:0] ports_of2();
      return {if2.Lport, if2.Sport, if2.Wport, if2.Eport, if2.Nport};
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: route from coordinate differences, packet tracked as none/forwarding/discarding
   int         m_mode  [2];
   logic [4:0] m_ports [2];
   logic       m_busy  [2];
   logic       m_err   [2];
   logic [3:0] m_cur   [2];
   logic [7:0] m_rxy   [2];
   logic [3:0] m_cx    [2];
   logic [1:0] m_dr    [2];

   function automatic logic [4:0] mroute(int xb, int c, int d, logic [7:0] r, logic [3:0] con,
                                         logic [1:0] drs, bit en);
      int xc, yc, xd, yd, dx, dy;
      logic [4:0] res;
      xc = c & ((1 << xb) - 1);  yc = c >> xb;
      xd = d & ((1 << xb) - 1);  yd = d >> xb;
      dx = xd - xc;  dy = yd - yc;
      if (dx == 0 && dy == 0) return PL;
      res = 5'b0;
      if (dy < 0) res[0] = (dx == 0) || (dx > 0 ? r[0] : r[1]);
      if (dx > 0) res[1] = (dy == 0) || (dy < 0 ? r[2] : r[3]);
      if (dx < 0) res[2] = (dy == 0) || (dy < 0 ? r[4] : r[5]);
      if (dy > 0) res[3] = (dx == 0) || (dx > 0 ? r[6] : r[7]);
      res[3:0] = res[3:0] & con;
      if (res == 5'b0 && en && con[drs]) res = 5'b00001 << drs;
      return res;
   endfunction

   task automatic model_step(int k);
      logic [4:0] r;
      bit starts;
      if (!rst) begin
         m_cur[k] = cur;  m_rxy[k] = rxy;  m_cx[k] = cx;  m_dr[k] = dr;
         m_mode[k] = 0;  m_ports[k] = PZ;  m_busy[k] = 1'b0;  m_err[k] = 1'b0;
         return;
      end
      m_err[k] = 1'b0;
      if (empty) begin
         if (m_mode[k] != 1) m_ports[k] = PZ;
      end else begin
         r = mroute(2, int'(m_cur[k]), int'(dst), m_rxy[k], m_cx[k], m_dr[k], k == 0);
         starts = (fid == H || fid == HT);
         if (m_mode[k] == 1 && starts) m_err[k] = 1'b1;
         if (m_mode[k] == 0 || (m_mode[k] == 1 && starts)) begin
            if (starts) begin
               m_ports[k] = r;
               if (r == PZ) m_err[k] = 1'b1;
               m_mode[k] = (fid == HT) ? 0 : ((r != PZ) ? 1 : 2);
            end else begin
               m_ports[k] = PZ;
               m_err[k]   = 1'b1;
            end
         end else if (fid == T) begin
            m_ports[k] = PZ;
            m_mode[k]  = 0;
         end
      end
      m_busy[k] = (m_mode[k] != 0);
   endtask

   task automatic tick();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      chk("model d0 ports", 8'(ports_of0()), 8'(m_ports[0]));
      chk("model d0 busy",  8'(if0.busy),      8'(m_busy[0]));
      chk("model d0 err",   8'(if0.route_err), 8'(m_err[0]));
      chk("model d1 ports", 8'(ports_of1()), 8'(m_ports[1]));
      chk("model d1 busy",  8'(if1.busy),      8'(m_busy[1]));
      chk("model d1 err",   8'(if1.route_err), 8'(m_err[1]));
   endtask

   typedef struct {
      logic       rst;
      logic       empty;
      logic [2:0] fid;
      logic [3:0] dst;
      logic [3:0] cx;
      logic [4:0] p0; logic b0; logic e0;
      logic [4:0] p1; logic b1; logic e1;
   } vec_t;

   vec_t tbl[$];

   initial begin
      rst = 1'b0; empty = 1'b1; fid = B; dst = 4'd0; cur = 4'd5; cx = 4'hF; rxy = 8'h3C; dr = 2'b00;
      rst2 = 1'b0; empty2 = 1'b1; fid2 = B; dst2 = 6'd0; cur2 = 6'd9;

      //               rst   emp   fid   dst    cx       p0  b0    e0    p1  b1    e1
      tbl.push_back('{1'b0, 1'b1, B,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, H,    4'd6,  4'hF,    PE, 1'b1, 1'b0, PE, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b1, B,    4'd0,  4'hF,    PE, 1'b1, 1'b0, PE, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, B,    4'd0,  4'hF,    PE, 1'b1, 1'b0, PE, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b1, B,    4'd0,  4'hF,    PE, 1'b1, 1'b0, PE, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 3'b011, 4'd0, 4'hF,   PE, 1'b1, 1'b0, PE, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, T,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, B,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, H,    4'd5,  4'hF,    PL, 1'b1, 1'b0, PL, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, T,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, H,    4'd1,  4'hF,    PN, 1'b1, 1'b0, PN, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, T,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, H,    4'd13, 4'hF,    PS, 1'b1, 1'b0, PS, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, T,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, H,    4'd4,  4'hF,    PW, 1'b1, 1'b0, PW, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, T,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, B,    4'd0,  4'hF,    PZ, 1'b0, 1'b1, PZ, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b0, T,    4'd0,  4'hF,    PZ, 1'b0, 1'b1, PZ, 1'b0, 1'b1});
      tbl.push_back('{1'b1, 1'b1, B,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, H,    4'd6,  4'hF,    PE, 1'b1, 1'b0, PE, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, H,    4'd4,  4'hF,    PW, 1'b1, 1'b1, PW, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 1'b0, T,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, HT,   4'd6,  4'hF,    PE, 1'b0, 1'b0, PE, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b1, B,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, B,    4'd0,  4'b1101, PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b1, 1'b0, H,    4'd6,  4'b1101, PN, 1'b1, 1'b0, PZ, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 1'b0, B,    4'd0,  4'b1101, PN, 1'b1, 1'b0, PZ, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b1, B,    4'd0,  4'b1101, PN, 1'b1, 1'b0, PZ, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, T,    4'd0,  4'b1101, PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, B,    4'd0,  4'hF,    PZ, 1'b0, 1'b0, PZ, 1'b0, 1'b0});

      @(negedge clk);
      foreach (tbl[i]) begin
         rst = tbl[i].rst; empty = tbl[i].empty; fid = tbl[i].fid; dst = tbl[i].dst; cx = tbl[i].cx;
         tick();
         chk($sformatf("tbl[%0d] d0 ports", i), 8'(ports_of0()),    8'(tbl[i].p0));
         chk($sformatf("tbl[%0d] d0 busy", i),  8'(if0.busy),       8'(tbl[i].b0));
         chk($sformatf("tbl[%0d] d0 err", i),   8'(if0.route_err),  8'(tbl[i].e0));
         chk($sformatf("tbl[%0d] d1 ports", i), 8'(ports_of1()),    8'(tbl[i].p1));
         chk($sformatf("tbl[%0d] d1 busy", i),  8'(if1.busy),       8'(tbl[i].b1));
         chk($sformatf("tbl[%0d] d1 err", i),   8'(if1.route_err),  8'(tbl[i].e1));
      end

      for (int n = 0; n < 1500; n++) begin
         int sel;
         rst = ($urandom_range(0, 59) != 0);
         if (!rst) begin
            cur = 4'($urandom_range(0, 15));
            rxy = ($urandom_range(0, 1) != 0) ? 8'h3C : 8'hC3;
            cx  = 4'($urandom);
            dr  = 2'($urandom);
         end
         empty = ($urandom_range(0, 9) < 3);
         dst   = 4'($urandom);
         sel   = int'($urandom_range(0, 9));
         if (sel < 2)       fid = H;
         else if (sel < 5)  fid = B;
         else if (sel < 7)  fid = T;
         else if (sel == 7) fid = HT;
         else               fid = 3'($urandom);
         tick();
      end

      rst = 1'b1; empty = 1'b1;
      rst2 = 1'b0; cur2 = 6'd9; empty2 = 1'b1;
      tick();
      chk("wide reset ports", 8'(ports_of2()), 8'(PZ));
      chk("wide reset busy",  8'(if2.busy),    8'd0);
      rst2 = 1'b1; empty2 = 1'b0; fid2 = H; dst2 = 6'd13;
      tick();
      chk("wide hdr ports", 8'(ports_of2()), 8'(PE));
      chk("wide hdr busy",  8'(if2.busy),    8'd1);
      fid2 = B;
      tick();
      chk("wide body ports", 8'(ports_of2()), 8'(PE));
      rst2 = 1'b0; cur2 = 6'd13;
      tick();
      chk("wide midrst ports", 8'(ports_of2()),   8'(PZ));
      chk("wide midrst busy",  8'(if2.busy),      8'd0);
      chk("wide midrst err",   8'(if2.route_err), 8'd0);
      rst2 = 1'b1; fid2 = H; dst2 = 6'd9;
      tick();
      chk("wide newcfg ports", 8'(ports_of2()), 8'(PW));
      chk("wide newcfg busy",  8'(if2.busy),    8'd1);
      fid2 = T;
      tick();
      chk("wide tail ports", 8'(ports_of2()), 8'(PZ));
      chk("wide tail busy",  8'(if2.busy),    8'd0);
      fid2 = B;
      tick();
      chk("wide idle body err", 8'(if2.route_err), 8'd1);
      chk("wide idle body ports", 8'(ports_of2()), 8'(PZ));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
